// File: rtl/tape_loader.sv
// tape_loader: shifts in TAPE_W debounced switch bits, pulses tm_reset, then holds the tape with ready until done_in.
// Latency: tm_reset 1 cycle after the final accept, ready the cycle after; strobes while busy are dropped, not queued.
// Optional TAPE_LOADER_TIMEOUT_EN: err and HALTED after TIMEOUT_CYCLES ARM cycles with no done_in.
module tape_loader #(
   parameter int TAPE_W          = 8,
   parameter int DEBOUNCE_CYCLES = 16
`ifdef TAPE_LOADER_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES  = 64
`endif
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          bit_in,
   input  logic                          bit_strobe,
   input  logic                          clear,
   input  logic                          done_in,
   output logic [TAPE_W-1:0]             tape_out,
   output logic [$clog2(TAPE_W+1)-1:0]   bit_count,
   output logic                          tm_reset,
   output logic                          ready,
   output logic                          busy,
   output logic                          err
);

   localparam int CW = $clog2(TAPE_W+1);
   localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   typedef enum logic [1:0] {COLLECT, LAUNCH, ARM, HALTED} state_t;

   state_t        state;
   logic          bit_meta, bit_sync;
   logic          stb_meta, stb_sync;
   logic          db_level, db_level_d;
   logic [DW-1:0] db_cnt;
   logic          accept;

`ifdef TAPE_LOADER_TIMEOUT_EN
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [TW-1:0] to_cnt;
   logic          err_q;
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         bit_meta <= 1'b0;
         bit_sync <= 1'b0;
         stb_meta <= 1'b0;
         stb_sync <= 1'b0;
      end else begin
         bit_meta <= bit_in;
         bit_sync <= bit_meta;
         stb_meta <= bit_strobe;
         stb_sync <= stb_meta;
      end
   end

   // The level only moves after the synced strobe has disagreed with it for DEBOUNCE_CYCLES straight cycles.
   always_ff @(posedge clk) begin
      if (reset) begin
         db_level   <= 1'b0;
         db_level_d <= 1'b0;
         db_cnt     <= '0;
      end else begin
         db_level_d <= db_level;
         if (stb_sync == db_level) begin
            db_cnt <= '0;
         end else if (db_cnt == DW'(DEBOUNCE_CYCLES-1)) begin
            db_level <= stb_sync;
            db_cnt   <= '0;
         end else begin
            db_cnt <= db_cnt + DW'(1);
         end
      end
   end

   assign accept = db_level & ~db_level_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= COLLECT;
         tape_out  <= '0;
         bit_count <= '0;
         tm_reset  <= 1'b0;
         ready     <= 1'b0;
         busy      <= 1'b0;
`ifdef TAPE_LOADER_TIMEOUT_EN
         err_q     <= 1'b0;
         to_cnt    <= '0;
`endif
      end else begin
         tm_reset <= 1'b0;
         if (clear) begin
            state     <= COLLECT;
            tape_out  <= '0;
            bit_count <= '0;
            ready     <= 1'b0;
            busy      <= 1'b0;
`ifdef TAPE_LOADER_TIMEOUT_EN
            err_q     <= 1'b0;
`endif
         end else begin
            case (state)
               COLLECT: begin
                  if (accept) begin
                     tape_out <= {tape_out[TAPE_W-2:0], bit_sync};
                     if (bit_count >= CW'(TAPE_W-1)) begin
                        bit_count <= CW'(TAPE_W);
                        state     <= LAUNCH;
                        tm_reset  <= 1'b1;
                        busy      <= 1'b1;
                     end else begin
                        bit_count <= bit_count + CW'(1);
                     end
                  end
               end
               LAUNCH: begin
                  state <= ARM;
                  ready <= 1'b1;
`ifdef TAPE_LOADER_TIMEOUT_EN
                  to_cnt <= '0;
`endif
               end
               ARM: begin
                  if (done_in) begin
                     state <= HALTED;
                     ready <= 1'b0;
                     busy  <= 1'b0;
                  end
`ifdef TAPE_LOADER_TIMEOUT_EN
                  else if (to_cnt == TW'(TIMEOUT_CYCLES-1)) begin
                     state <= HALTED;
                     ready <= 1'b0;
                     busy  <= 1'b0;
                     err_q <= 1'b1;
                  end else begin
                     to_cnt <= to_cnt + TW'(1);
                  end
`endif
               end
               HALTED: ;
               default: state <= COLLECT;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_tape_loader.sv
// Bench for tape_loader: spec-level model checked every cycle, plus hand-computed directed expectations.
`timescale 1ns/1ps
module tb_tape_loader;
   localparam int TAPE_W = 8;
   localparam int DEB    = 4;
   localparam int TMO    = 16;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       bit_in = 1'b0, bit_strobe = 1'b0, clear = 1'b0, done_in = 1'b0;
   logic [7:0] tape_out;
   logic [3:0] bit_count;
   logic       tm_reset, ready, busy, err;

   always #5 clk = ~clk;

   tape_loader #(
      .TAPE_W(TAPE_W),
      .DEBOUNCE_CYCLES(DEB)
`ifdef TAPE_LOADER_TIMEOUT_EN
      ,
      .TIMEOUT_CYCLES(TMO)
`endif
   ) dut (
      .clk(clk), .reset(reset), .bit_in(bit_in), .bit_strobe(bit_strobe),
      .clear(clear), .done_in(done_in), .tape_out(tape_out), .bit_count(bit_count),
      .tm_reset(tm_reset), .ready(ready), .busy(busy), .err(err)
   );

   int ncmp = 0;
   int nerr = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      ncmp++;
      if (got !== want) begin
         nerr++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, got, want, $time);
      end
   endtask

   // Model: phases 0 collecting, 1 launching, 2 armed, 3 halted; raw pins seen two edges late.
   bit         mv = 0;
   int         m_phase, m_cnt, m_arm, run;
   logic [7:0] m_tape;
   bit         m_tm, m_ready, m_busy, m_err, m_acc;
   bit         s1, s2, b1, b2, lvl, lvl_d;

   always @(posedge clk) begin
      mv = 1;
      if (reset) begin
         m_phase = 0; m_cnt = 0; m_arm = 0; run = 0; m_tape = 0;
         m_tm = 0; m_ready = 0; m_busy = 0; m_err = 0;
         s1 = 0; s2 = 0; b1 = 0; b2 = 0; lvl = 0; lvl_d = 0;
      end else begin
         m_acc = lvl && !lvl_d;
         m_tm  = 0;
         if (clear) begin
            m_phase = 0; m_cnt = 0; m_tape = 0; m_ready = 0; m_busy = 0; m_err = 0;
         end else if (m_phase == 0) begin
            if (m_acc) begin
               m_tape = {m_tape[6:0], b2};
               m_cnt++;
               if (m_cnt == TAPE_W) begin
                  m_phase = 1; m_tm = 1; m_busy = 1;
               end
            end
         end else if (m_phase == 1) begin
            m_phase = 2; m_ready = 1; m_arm = 0;
         end else if (m_phase == 2) begin
            if (done_in) begin
               m_phase = 3; m_ready = 0; m_busy = 0;
            end
`ifdef TAPE_LOADER_TIMEOUT_EN
            else begin
               m_arm++;
               if (m_arm == TMO) begin
                  m_phase = 3; m_ready = 0; m_busy = 0; m_err = 1;
               end
            end
`endif
         end
         lvl_d = lvl;
         if (s2 != lvl) begin
            run++;
            if (run == DEB) begin
               lvl = s2;
               run = 0;
            end
         end else begin
            run = 0;
         end
         s2 = s1; s1 = bit_strobe;
         b2 = b1; b1 = bit_in;
      end
   end

   always @(negedge clk) begin
      if (mv) begin
         ncmp++;
         if ({tape_out, bit_count, tm_reset, ready, busy, err} !==
             {m_tape, 4'(m_cnt), m_tm, m_ready, m_busy, m_err}) begin
            nerr++;
            $display("FAIL model t=%0t: got tape=%h cnt=%0d tm=%b rdy=%b busy=%b err=%b, want tape=%h cnt=%0d tm=%b rdy=%b busy=%b err=%b",
                     $time, tape_out, bit_count, tm_reset, ready, busy, err,
                     m_tape, m_cnt, m_tm, m_ready, m_busy, m_err);
         end
      end
   end

   int tm_pulses = 0;
   int rdy_run = 0;
   int last_rdy_run = 0;
   bit tm_prev = 0;

   always @(negedge clk) begin
      if (tm_prev) chk("ready_after_tm", ready, 1);
      if (tm_reset === 1'b1) begin
         tm_pulses++;
         chk("ready_low_at_tm", ready, 0);
      end
      tm_prev = (tm_reset === 1'b1);
      if (ready === 1'b1) begin
         rdy_run++;
      end else if (rdy_run > 0) begin
         last_rdy_run = rdy_run;
         rdy_run = 0;
      end
   end

   task automatic press(input logic b);
      @(negedge clk);
      bit_in = b;
      bit_strobe = 1'b1;
      repeat (8) @(negedge clk);
      bit_strobe = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   task automatic pulse_clear();
      @(negedge clk) clear = 1'b1;
      @(negedge clk) clear = 1'b0;
   endtask

   logic [7:0] pat;
   int         p;

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_tape", tape_out, 0);
      chk("rst_cnt", bit_count, 0);
      chk("rst_tm", tm_reset, 0);
      chk("rst_ready", ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      reset = 1'b0;

      pat = 8'b1011_0111;
      for (int i = 0; i < 8; i++) begin
         press(pat[7-i]);
         chk("cnt_step", bit_count, i + 1);
      end
      chk("tape_b7", tape_out, 8'hB7);
      chk("tm_pulses_1", tm_pulses, 1);
      chk("arm_ready", ready, 1);
      chk("arm_busy", busy, 1);

      @(negedge clk) done_in = 1'b1;
      @(negedge clk) done_in = 1'b0;
      chk("done_ready", ready, 0);
      chk("done_busy", busy, 0);
      press(1'b0);
      press(1'b1);
      chk("halt_tape", tape_out, 8'hB7);
      chk("halt_cnt", bit_count, 8);
      chk("halt_ready", ready, 0);

      pulse_clear();
      chk("clr_cnt", bit_count, 0);
      chk("clr_tape", tape_out, 0);
      bit_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bit_strobe = (i % 2 == 0);
         @(negedge clk);
      end
      bit_strobe = 1'b1;
      repeat (10) @(negedge clk);
      bit_strobe = 1'b0;
      repeat (10) @(negedge clk);
      chk("bounce_cnt", bit_count, 1);
      chk("bounce_tape", tape_out, 8'h01);

      pulse_clear();
      pat = 8'b1011_0000;
      for (int i = 0; i < 5; i++) press(pat[7-i]);
      chk("five_cnt", bit_count, 5);
      chk("five_tape", tape_out, 8'h16);
      @(negedge clk);
      bit_in = 1'b1;
      bit_strobe = 1'b1;
      repeat (6) @(negedge clk);
      clear = 1'b1;
      @(negedge clk) clear = 1'b0;
      chk("clracc_cnt", bit_count, 0);
      chk("clracc_tape", tape_out, 0);
      repeat (3) @(negedge clk);
      bit_strobe = 1'b0;
      repeat (8) @(negedge clk);
      chk("clracc_dropped", bit_count, 0);

      pulse_clear();
      for (int i = 0; i < 8; i++) press(1'b1);
      chk("ff_tape", tape_out, 8'hFF);
`ifdef TAPE_LOADER_TIMEOUT_EN
      for (int k = 0; k < 40 && err !== 1'b1; k++) @(negedge clk);
      @(negedge clk);
      chk("tmo_err", err, 1);
      chk("tmo_ready", ready, 0);
      chk("tmo_busy", busy, 0);
      chk("tmo_ready_cycles", last_rdy_run, TMO);
      pulse_clear();
      chk("tmo_err_cleared", err, 0);
`else
      repeat (40) @(negedge clk);
      chk("notmo_ready", ready, 1);
      chk("notmo_err", err, 0);
      chk("notmo_busy", busy, 1);
      pulse_clear();
`endif

      pat = 8'h5A;
      for (int i = 0; i < 8; i++) press(pat[7-i]);
      chk("r_arm_ready", ready, 1);
      chk("r_arm_tape", tape_out, 8'h5A);
      p = tm_pulses;
      @(negedge clk) reset = 1'b1;
      @(negedge clk);
      chk("r_tape", tape_out, 0);
      chk("r_cnt", bit_count, 0);
      chk("r_ready", ready, 0);
      chk("r_busy", busy, 0);
      chk("r_tm", tm_reset, 0);
      chk("r_err", err, 0);
      reset = 1'b0;
      repeat (10) @(negedge clk);
      chk("r_no_tm_pulse", tm_pulses, p);
      chk("tm_pulses_total", tm_pulses, 3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
